// File: rtl/qspi_target.sv
// rtl/qspi_target.sv - quad-SPI memory responder (0xEB read, optional 0x38 write under QSPI_TARGET_WRITE_EN)
module qspi_target #(
    parameter int AW    = 24,
    parameter int DUMMY = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          sclk,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic [3:0]    io_oe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  cs_s;
    logic [1:0]  sclk_s;
    logic [3:0]  io_s1;
    logic [3:0]  io_s2;
    logic        sclk_d;
    logic        rise;
    logic        fall;
    logic        cs_hi;
    logic [3:0]  cmd_hi;
    logic [23:0] addr_sh;
    logic [23:0] addr_next;
    logic [7:0]  cnt;
    logic [7:0]  sreg;
    logic [3:0]  lo_nib;
    logic        nib_sel;
    logic        rd_wait;

    assign rise      = sclk_s[1] & ~sclk_d;
    assign fall      = ~sclk_s[1] & sclk_d;
    assign cs_hi     = cs_s[1];
    assign addr_next = {addr_sh[19:0], io_s2};

    // Data is synchronized with the same depth as sclk so a rise sees the matching nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s   <= 2'b11;
            sclk_s <= 2'b00;
            io_s1  <= 4'h0;
            io_s2  <= 4'h0;
            sclk_d <= 1'b0;
        end else begin
            cs_s   <= {cs_s[0], cs_n};
            sclk_s <= {sclk_s[0], sclk};
            io_s1  <= io_in;
            io_s2  <= io_s1;
            sclk_d <= sclk_s[1];
        end
    end

`ifdef QSPI_TARGET_WRITE_EN
    logic       is_wr;
    logic [3:0] wnib;
    logic       wr_q;
    logic [7:0] wdata_q;

    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
`else
    assign mem_wr    = 1'b0;
    assign mem_wdata = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            io_out   <= 4'h0;
            io_oe    <= 4'h0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            cmd_hi   <= 4'h0;
            addr_sh  <= 24'h0;
            cnt      <= 8'd0;
            sreg     <= 8'h00;
            lo_nib   <= 4'h0;
            nib_sel  <= 1'b0;
            rd_wait  <= 1'b0;
`ifdef QSPI_TARGET_WRITE_EN
            is_wr    <= 1'b0;
            wnib     <= 4'h0;
            wr_q     <= 1'b0;
            wdata_q  <= 8'h00;
`endif
        end else begin
            mem_rd  <= 1'b0;
            rd_wait <= mem_rd;
            // Read data arrives the cycle after the strobe; it is kept even if cs has dropped.
            if (rd_wait)
                sreg <= mem_rdata;
`ifdef QSPI_TARGET_WRITE_EN
            wr_q <= 1'b0;
            if (wr_q)
                mem_addr <= mem_addr + AW'(1);
`endif
            if (cs_hi) begin
                state   <= ST_IDLE;
                io_oe   <= 4'h0;
                io_out  <= 4'h0;
                nib_sel <= 1'b0;
                cnt     <= 8'd0;
            end else begin
                case (state)
                    ST_IDLE: if (rise) begin
                        cmd_hi <= io_s2;
                        state  <= ST_CMD;
                    end
                    ST_CMD: if (rise) begin
                        cnt <= 8'd0;
                        if ({cmd_hi, io_s2} == 8'hEB) begin
`ifdef QSPI_TARGET_WRITE_EN
                            is_wr <= 1'b0;
`endif
                            state <= ST_ADDR;
                        end
`ifdef QSPI_TARGET_WRITE_EN
                        else if ({cmd_hi, io_s2} == 8'h38) begin
                            is_wr <= 1'b1;
                            state <= ST_ADDR;
                        end
`endif
                        else
                            state <= ST_IGNORE;
                    end
                    ST_ADDR: if (rise) begin
                        addr_sh <= addr_next;
                        if (cnt == 8'd5) begin
                            cnt      <= 8'd0;
                            mem_addr <= AW'(addr_next);
                            nib_sel  <= 1'b0;
`ifdef QSPI_TARGET_WRITE_EN
                            if (is_wr)
                                state <= ST_WDATA;
                            else
`endif
                            begin
                                state  <= ST_DUMMY;
                                mem_rd <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ST_DUMMY: if (rise) begin
                        if (cnt == 8'(DUMMY - 1)) begin
                            cnt     <= 8'd0;
                            nib_sel <= 1'b0;
                            state   <= ST_RDATA;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    // Low nibble is parked in lo_nib so the prefetch can overwrite sreg.
                    ST_RDATA: if (fall) begin
                        io_oe <= 4'hF;
                        if (!nib_sel) begin
                            io_out   <= sreg[7:4];
                            lo_nib   <= sreg[3:0];
                            mem_addr <= mem_addr + AW'(1);
                            mem_rd   <= 1'b1;
                        end else begin
                            io_out <= lo_nib;
                        end
                        nib_sel <= ~nib_sel;
                    end
`ifdef QSPI_TARGET_WRITE_EN
                    ST_WDATA: if (rise) begin
                        if (!nib_sel) begin
                            wnib <= io_s2;
                        end else begin
                            wdata_q <= {wnib, io_s2};
                            wr_q    <= 1'b1;
                        end
                        nib_sel <= ~nib_sel;
                    end
`endif
                    ST_IGNORE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_target.sv
// tb/tb_qspi_target.sv - directed self-checking bench for qspi_target
module tb_qspi_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        sclk;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_wr;
    logic [7:0]  mem_wdata;

    qspi_target #(.AW(24), .DUMMY(4)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  store [0:4095];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        oe_seen = 1'b0;
    logic        saw_rd_zero = 1'b0;
    logic [23:0] wa_q [$];
    logic [7:0]  wd_q [$];
    logic [3:0]  last_oe;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (mem_rd) begin
                rd_cnt <= rd_cnt + 1;
                mem_rdata <= store[mem_addr[11:0]];
                if (mem_addr == 24'h0) saw_rd_zero <= 1'b1;
            end
            if (mem_wr) begin
                wr_cnt <= wr_cnt + 1;
                store[mem_addr[11:0]] <= mem_wdata;
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
            end
            if (io_oe != 4'h0) oe_seen <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One SCLK period: present nibble, sample io_out just before the rise, then fall.
    task automatic sclk_cycle(input logic [3:0] n, output logic [3:0] o);
        io_in = n;
        repeat (6) @(negedge clk);
        o = io_out;
        last_oe = io_oe;
        sclk = 1'b1;
        repeat (6) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] d;
        sclk_cycle(b[7:4], d);
        sclk_cycle(b[3:0], d);
    endtask

    task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] d;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(cmd);
        for (int i = 5; i >= 0; i--) sclk_cycle(addr[i*4 +: 4], d);
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic dummies();
        logic [3:0] d;
        for (int i = 0; i < 4; i++) sclk_cycle(4'h0, d);
    endtask

    int         rd0;
    int         wr0;
    logic [3:0] nib [4];
    logic [3:0] d;

    initial begin
        for (int i = 0; i < 4096; i++) store[i] = 8'h00;
        store[12'h010] = 8'hA5;
        store[12'h011] = 8'h3C;
        store[12'hFFF] = 8'h12;
        store[12'h000] = 8'h34;
        mem_rdata = 8'h00;
        reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; io_in = 4'h0;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Idle with sclk toggling and cs_n high
        for (int i = 0; i < 10; i++) sclk_cycle(4'h5, d);
        check("idle_io_out", 32'(io_out), 32'h0);
        check("idle_io_oe", 32'(io_oe), 32'h0);
        check("idle_mem_addr", 32'(mem_addr), 32'h0);
        check("idle_rd_cnt", rd_cnt, 0);
        check("idle_wr_cnt", wr_cnt, 0);

        // Read two bytes from 0x10
        rd0 = rd_cnt;
        start_txn(8'hEB, 24'h000010);
        dummies();
        for (int i = 0; i < 4; i++) begin
            sclk_cycle(4'h0, nib[i]);
            if (i == 0) check("rd_oe_first", 32'(last_oe), 32'hF);
        end
        check("rd_nib0", 32'(nib[0]), 32'hA);
        check("rd_nib1", 32'(nib[1]), 32'h5);
        check("rd_nib2", 32'(nib[2]), 32'h3);
        check("rd_nib3", 32'(nib[3]), 32'hC);
        check("rd_count", rd_cnt - rd0, 3);
        check("rd_addr_end", 32'(mem_addr), 32'h12);
        end_txn();
        check("rd_oe_after_cs", 32'(io_oe), 32'h0);

        // Read across the top of the address space
        saw_rd_zero = 1'b0;
        start_txn(8'hEB, 24'hFFFFFF);
        dummies();
        for (int i = 0; i < 4; i++) sclk_cycle(4'h0, nib[i]);
        check("wrap_nib0", 32'(nib[0]), 32'h1);
        check("wrap_nib1", 32'(nib[1]), 32'h2);
        check("wrap_nib2", 32'(nib[2]), 32'h3);
        check("wrap_nib3", 32'(nib[3]), 32'h4);
        check("wrap_rd_zero", 32'(saw_rd_zero), 32'h1);
        check("wrap_addr_end", 32'(mem_addr), 32'h1);
        end_txn();

        // Quad write
        wr0 = wr_cnt;
        oe_seen = 1'b0;
        start_txn(8'h38, 24'h000100);
        sclk_cycle(4'hD, d);
        sclk_cycle(4'hE, d);
        sclk_cycle(4'hA, d);
        sclk_cycle(4'hD, d);
        repeat (4) @(negedge clk);
        end_txn();
`ifdef QSPI_TARGET_WRITE_EN
        check("wr_count", wr_cnt - wr0, 2);
        if (wa_q.size() >= 2) begin
            check("wr_addr0", 32'(wa_q[0]), 32'h100);
            check("wr_data0", 32'(wd_q[0]), 32'hDE);
            check("wr_addr1", 32'(wa_q[1]), 32'h101);
            check("wr_data1", 32'(wd_q[1]), 32'hAD);
        end
`else
        check("wr_disabled_count", wr_cnt - wr0, 0);
        check("wr_disabled_oe", 32'(oe_seen), 32'h0);
`endif

        // Unknown command followed by 20 clocks
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        oe_seen = 1'b0;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h9F);
        for (int i = 0; i < 20; i++) sclk_cycle(4'hF, d);
        end_txn();
        check("unk_rd", rd_cnt - rd0, 0);
        check("unk_wr", wr_cnt - wr0, 0);
        check("unk_oe", 32'(oe_seen), 32'h0);
        start_txn(8'hEB, 24'h000010);
        dummies();
        sclk_cycle(4'h0, nib[0]);
        sclk_cycle(4'h0, nib[1]);
        end_txn();
        check("unk_next_nib0", 32'(nib[0]), 32'hA);
        check("unk_next_nib1", 32'(nib[1]), 32'h5);

        // Abort a read after 3 data nibbles
        start_txn(8'hEB, 24'h000010);
        dummies();
        for (int i = 0; i < 3; i++) sclk_cycle(4'h0, nib[i]);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_rd_oe", 32'(io_oe), 32'h0);
        repeat (5) @(negedge clk);
        start_txn(8'hEB, 24'h000010);
        dummies();
        sclk_cycle(4'h0, nib[0]);
        sclk_cycle(4'h0, nib[1]);
        end_txn();
        check("abort_next_nib0", 32'(nib[0]), 32'hA);
        check("abort_next_nib1", 32'(nib[1]), 32'h5);

        // Abort a write after 1 nibble
        wr0 = wr_cnt;
        start_txn(8'h38, 24'h000200);
        sclk_cycle(4'h7, d);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_wr_oe", 32'(io_oe), 32'h0);
        repeat (5) @(negedge clk);
        check("abort_wr_count", wr_cnt - wr0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
